wave_capture_ctrl: RTL and testbench
====================================

# wave_capture_ctrl

Capture sequencer for the signal-generator waveform display. Takes the sample stream and writes one triggered, decimated record of 1024 samples into one half of a ping-pong waveform RAM. The display read path scans the other half. At frame boundaries it swaps halves, so the displayed trace never tears mid-frame.

## Interface
Parameters:
- ADDR_W, 10, record address width; record depth = 2**ADDR_W
- DATA_W, 12, sample width
- TMO_W, 16, width of auto-trigger timeout counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- run  in  1  capture enable; low aborts to IDLE
- sample_valid  in  1  sample strobe
- sample_data  in  DATA_W  sample value, unsigned
- trig_en  in  1  1 = level trigger, 0 = free-run (trigger on first accepted sample)
- trig_level  in  DATA_W  rising-edge trigger threshold
- tmo_limit  in  TMO_W  accepted samples in ARM before forced trigger; 0 disables timeout
- decim  in  8  accept 1 of every decim+1 valid samples
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- ram_wr_en  out  1  RAM write strobe
- ram_wr_addr  out  ADDR_W+1  {wr_bank, index}
- ram_wr_data  out  DATA_W  write data
- disp_bank  out  1  bank the display read path uses as address MSB
- busy  out  1  high in ARM or CAPTURE
- swap_pulse  out  1  one cycle when banks swap

## Operation
- Acceptance: a decimation counter counts valid samples. A sample is accepted when sample_valid=1 and counter==decim; the counter then clears, otherwise it increments. The counter clears on entry to ARM. Samples with sample_valid=0 are ignored.
- prev_sample register: holds the last accepted sample. prev_ok marks it valid and clears on entry to ARM.
- States:
  - IDLE: outputs quiet. Goes to ARM when run=1.
  - ARM: on each accepted sample, evaluates trigger. Trigger fires when any of these holds:
    - trig_en=0
    - prev_ok=1 and prev_sample < trig_level and sample >= trig_level
    - tmo_limit != 0 and timeout count reaches tmo_limit-1 on this accepted sample
  - On trigger: the triggering sample is written at index 0 and the state moves to CAPTURE with index=1. The timeout count increments per accepted sample in ARM and clears on entry.
  - CAPTURE: each accepted sample is written at the current index, then index increments. The write at index 2**ADDR_W-1 moves the state to DONE.
  - DONE: no writes. On frame_start: wr_bank toggles, disp_bank = new ~wr_bank, swap_pulse=1, state moves to ARM.
- run=0 in any state moves to IDLE next cycle. A partial record is discarded, with no swap and banks unchanged. A write already issued for that cycle still completes.
- frame_start outside DONE is ignored.
- Comparisons are unsigned, full DATA_W. The index wraps only via the DONE transition and never exceeds 2**ADDR_W-1.
- wr_bank and disp_bank are always complementary.

## Timing
- Reset values:
  - state IDLE
  - ram_wr_en 0, ram_wr_addr 0, ram_wr_data 0
  - wr_bank 0, disp_bank 1
  - busy 0, swap_pulse 0
  - all counters 0, prev_ok 0
- Write latency: an accepted sample in cycle N drives ram_wr_en=1 with its addr/data in cycle N+1, registered. ram_wr_en is high for exactly one cycle per write.
- busy and the state update at the same edge as the write registration. busy is 1 in cycle N+1 after the final write's acceptance and 0 in the following cycle.
- Swap: frame_start in DONE in cycle N gives disp_bank/wr_bank updated and swap_pulse=1 in cycle N+1, with ARM active from N+1.
- Simultaneous events:
  - frame_start in the same cycle as the final accepted sample: no swap; the swap occurs at the next frame_start.
  - run=0 together with an accepted sample: that sample is not written.
- Max throughput: one write per cycle when decim=0 and sample_valid is held high.

## Test plan
- Free-run:
  - Stimulus: run=1, trig_en=0, decim=0, sample_valid=1 continuous, ramp 0,1,2,...
  - Required: 1024 consecutive writes to addr 0..1023 with data 0..1023, then busy=0. A frame_start gives disp_bank 1->0, swap_pulse one cycle, and the next record goes to addr 1024..2047.
- Level trigger:
  - Stimulus: trig_level=2048, samples 100,1000,2047,2048,...
  - Required: first write is data 2048 at index 0. No writes for the earlier samples. A sample equal to threshold with prev >= threshold does not trigger.
- Decimation:
  - Stimulus: decim=3, ramp input.
  - Required: written data 0,4,8,...; consecutive ram_wr_en pulses are 4 valid samples apart.
- Timeout:
  - Stimulus: trig_en=1, trig_level=4095, constant input 10, tmo_limit=5.
  - Required: the 5th accepted sample is written at index 0 and capture proceeds.
- Abort:
  - Stimulus: run dropped after 300 writes.
  - Required: IDLE next cycle, no further writes, disp_bank unchanged. Re-asserting run restarts at index 0 in the same wr_bank.
- Reset and edge cases:
  - Stimulus: reset mid-CAPTURE; separately, frame_start coincident with the final sample.
  - Required: reset restores all reset values. The coincident frame_start causes no swap until the next frame_start pulse.

Source files
------------

// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for the waveform display: triggered, decimated record capture
// into one half of a ping-pong RAM, with bank swap at frame boundaries.
module wave_capture_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 12,
   parameter int TMO_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_data,
   input  logic              trig_en,
   input  logic [DATA_W-1:0] trig_level,
   input  logic [TMO_W-1:0]  tmo_limit,
   input  logic [7:0]        decim,
   input  logic              frame_start,
   output logic              ram_wr_en,
   output logic [ADDR_W:0]   ram_wr_addr,
   output logic [DATA_W-1:0] ram_wr_data,
   output logic              disp_bank,
   output logic              busy,
   output logic              swap_pulse
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_CAPTURE = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   localparam logic [TMO_W-1:0]  TMO_ONE = {{(TMO_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] IDX_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] IDX_MAX = {ADDR_W{1'b1}};

   state_t              state_q, state_d;
   logic [7:0]          decim_cnt_q, decim_cnt_d;
   logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [DATA_W-1:0]   prev_sample_q, prev_sample_d;
   logic                prev_ok_q, prev_ok_d;
   logic                wr_bank_q, wr_bank_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W:0]     wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]   wr_data_q, wr_data_d;
   logic                busy_q, busy_d;
   logic                swap_q, swap_d;

   logic accept_s;
   logic rise_s;
   logic tmo_hit_s;
   logic trigger_s;

   // Sample acceptance and trigger qualification for the current cycle.
   always_comb begin
      accept_s  = sample_valid && (decim_cnt_q == decim);
      rise_s    = prev_ok_q && (prev_sample_q < trig_level) && (sample_data >= trig_level);
      tmo_hit_s = (tmo_limit != {TMO_W{1'b0}}) && (tmo_cnt_q == (tmo_limit - TMO_ONE));
      trigger_s = !trig_en || rise_s || tmo_hit_s;
   end

   // Next-state, write-port and bank-swap computation.
   always_comb begin
      state_d       = state_q;
      decim_cnt_d   = decim_cnt_q;
      tmo_cnt_d     = tmo_cnt_q;
      idx_d         = idx_q;
      prev_sample_d = prev_sample_q;
      prev_ok_d     = prev_ok_q;
      wr_bank_d     = wr_bank_q;
      wr_en_d       = 1'b0;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      swap_d        = 1'b0;

      if (sample_valid) begin
         decim_cnt_d = accept_s ? 8'd0 : (decim_cnt_q + 8'd1);
      end else begin
         decim_cnt_d = decim_cnt_q;
      end

      if (accept_s) begin
         prev_sample_d = sample_data;
         prev_ok_d     = 1'b1;
      end else begin
         prev_sample_d = prev_sample_q;
      end

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d     = S_ARM;
               decim_cnt_d = 8'd0;
               tmo_cnt_d   = {TMO_W{1'b0}};
               prev_ok_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ARM: begin
            if (accept_s) begin
               tmo_cnt_d = tmo_cnt_q + TMO_ONE;
               if (trigger_s) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = {wr_bank_q, {ADDR_W{1'b0}}};
                  wr_data_d = sample_data;
                  idx_d     = IDX_ONE;
                  state_d   = S_CAPTURE;
               end else begin
                  state_d = S_ARM;
               end
            end else begin
               state_d = S_ARM;
            end
         end
         S_CAPTURE: begin
            if (accept_s) begin
               wr_en_d   = 1'b1;
               wr_addr_d = {wr_bank_q, idx_q};
               wr_data_d = sample_data;
               if (idx_q == IDX_MAX) begin
                  idx_d   = {ADDR_W{1'b0}};
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end else begin
               state_d = S_CAPTURE;
            end
         end
         S_DONE: begin
            if (frame_start) begin
               wr_bank_d   = ~wr_bank_q;
               swap_d      = 1'b1;
               state_d     = S_ARM;
               decim_cnt_d = 8'd0;
               tmo_cnt_d   = {TMO_W{1'b0}};
               prev_ok_d   = 1'b0;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Dropping run discards the record in progress: no new write, no swap.
      if (!run) begin
         state_d   = S_IDLE;
         idx_d     = {ADDR_W{1'b0}};
         wr_bank_d = wr_bank_q;
         wr_en_d   = 1'b0;
         wr_addr_d = wr_addr_q;
         wr_data_d = wr_data_q;
         swap_d    = 1'b0;
      end else begin
         wr_en_d = wr_en_d;
      end

      busy_d = (state_d == S_ARM) || (state_d == S_CAPTURE) || wr_en_d;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         decim_cnt_q   <= 8'd0;
         tmo_cnt_q     <= {TMO_W{1'b0}};
         idx_q         <= {ADDR_W{1'b0}};
         prev_sample_q <= {DATA_W{1'b0}};
         prev_ok_q     <= 1'b0;
         wr_bank_q     <= 1'b0;
         wr_en_q       <= 1'b0;
         wr_addr_q     <= {(ADDR_W+1){1'b0}};
         wr_data_q     <= {DATA_W{1'b0}};
         busy_q        <= 1'b0;
         swap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         decim_cnt_q   <= decim_cnt_d;
         tmo_cnt_q     <= tmo_cnt_d;
         idx_q         <= idx_d;
         prev_sample_q <= prev_sample_d;
         prev_ok_q     <= prev_ok_d;
         wr_bank_q     <= wr_bank_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         busy_q        <= busy_d;
         swap_q        <= swap_d;
      end
   end

   assign ram_wr_en   = wr_en_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign disp_bank   = ~wr_bank_q;
   assign busy        = busy_q;
   assign swap_pulse  = swap_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed self-checking bench for wave_capture_ctrl: free-run, level trigger,
// abort/restart, decimation, timeout, reset mid-capture and coincident frame_start.
module tb_wave_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        sample_valid;
   logic [11:0] sample_data;
   logic        trig_en;
   logic [11:0] trig_level;
   logic [15:0] tmo_limit;
   logic [7:0]  decim;
   logic        frame_start;
   logic        ram_wr_en;
   logic [10:0] ram_wr_addr;
   logic [11:0] ram_wr_data;
   logic        disp_bank;
   logic        busy;
   logic        swap_pulse;

   int checks = 0;
   int errors = 0;

   logic [11:0] lvl_v [6] = '{12'd2100, 12'd2048, 12'd100, 12'd1000, 12'd2047, 12'd2048};

   always #5 clk = ~clk;

   wave_capture_ctrl #(.ADDR_W(10), .DATA_W(12), .TMO_W(16)) dut (
      .clk(clk), .rst(rst), .run(run),
      .sample_valid(sample_valid), .sample_data(sample_data),
      .trig_en(trig_en), .trig_level(trig_level), .tmo_limit(tmo_limit),
      .decim(decim), .frame_start(frame_start),
      .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
      .disp_bank(disp_bank), .busy(busy), .swap_pulse(swap_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_we"},   32'(ram_wr_en),   32'd0);
      chk({tag, "_addr"}, 32'(ram_wr_addr), 32'd0);
      chk({tag, "_data"}, 32'(ram_wr_data), 32'd0);
      chk({tag, "_disp"}, 32'(disp_bank),   32'd1);
      chk({tag, "_busy"}, 32'(busy),        32'd0);
      chk({tag, "_swap"}, 32'(swap_pulse),  32'd0);
   endtask

   // Full free-run ramp record 0..1023, assuming ARM with trig_en=0 and decim=0.
   task automatic capture_ramp(input int base, input bit fs_last);
      for (int i = 0; i < 1024; i++) begin
         sample_valid = 1'b1;
         sample_data  = 12'(i);
         frame_start  = fs_last && (i == 1023);
         step();
         chk("ramp_we",   32'(ram_wr_en),   32'd1);
         chk("ramp_addr", 32'(ram_wr_addr), 32'(base + i));
         chk("ramp_data", 32'(ram_wr_data), 32'(i));
      end
      frame_start = 1'b0;
      chk("busy_on_last_write", 32'(busy), 32'd1);
      step();
      chk("done_no_write", 32'(ram_wr_en), 32'd0);
      chk("done_busy_low", 32'(busy),      32'd0);
      sample_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; run = 1'b0; sample_valid = 1'b0; sample_data = 12'd0;
      trig_en = 1'b0; trig_level = 12'd0; tmo_limit = 16'd0; decim = 8'd0;
      frame_start = 1'b0;
      step();
      step();
      chk_reset_vals("reset");
      rst = 1'b0;

      // Free-run record into bank 0, then swap on frame_start.
      run = 1'b1;
      step();
      chk("arm_busy", 32'(busy), 32'd1);
      capture_ramp(0, 1'b0);
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("swap_pulse", 32'(swap_pulse), 32'd1);
      chk("swap_disp",  32'(disp_bank),  32'd0);
      chk("swap_busy",  32'(busy),       32'd1);
      step();
      chk("swap_one_cycle", 32'(swap_pulse), 32'd0);

      // frame_start in ARM is ignored.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("fs_in_arm_swap", 32'(swap_pulse), 32'd0);
      chk("fs_in_arm_disp", 32'(disp_bank),  32'd0);

      // Level trigger in bank 1: only the rising crossing of 2048 fires.
      trig_en = 1'b1; trig_level = 12'd2048;
      for (int k = 0; k < 6; k++) begin
         sample_valid = 1'b1;
         sample_data  = lvl_v[k];
         step();
         chk("lvl_we", 32'(ram_wr_en), (k == 5) ? 32'd1 : 32'd0);
      end
      chk("lvl_addr", 32'(ram_wr_addr), 32'd1024);
      chk("lvl_data", 32'(ram_wr_data), 32'd2048);
      for (int i = 1; i < 300; i++) begin
         sample_data = 12'(i);
         step();
         chk("cap_addr", 32'(ram_wr_addr), 32'(1024 + i));
         chk("cap_data", 32'(ram_wr_data), 32'(i));
      end

      // Abort after 300 writes: accepted sample with run low is not written.
      run = 1'b0; sample_data = 12'd999;
      step();
      chk("abort_no_write", 32'(ram_wr_en), 32'd0);
      chk("abort_busy",     32'(busy),      32'd0);
      chk("abort_disp",     32'(disp_bank), 32'd0);
      step();
      chk("abort_idle_no_write", 32'(ram_wr_en), 32'd0);
      sample_valid = 1'b0; trig_en = 1'b0; run = 1'b1;
      step();
      sample_valid = 1'b1; sample_data = 12'd77;
      step();
      chk("restart_we",   32'(ram_wr_en),   32'd1);
      chk("restart_addr", 32'(ram_wr_addr), 32'd1024);
      chk("restart_data", 32'(ram_wr_data), 32'd77);
      run = 1'b0; sample_valid = 1'b0;
      step();

      // Decimation by 4: every 4th valid sample is accepted.
      decim = 8'd3; run = 1'b1;
      step();
      for (int k = 0; k < 68; k++) begin
         sample_valid = 1'b1;
         sample_data  = 12'(k - 3);
         step();
         chk("dec_we", 32'(ram_wr_en), ((k % 4) == 3) ? 32'd1 : 32'd0);
         if ((k % 4) == 3) begin
            chk("dec_addr", 32'(ram_wr_addr), 32'(1024 + k / 4));
            chk("dec_data", 32'(ram_wr_data), 32'(k - 3));
         end
      end
      run = 1'b0; sample_valid = 1'b0; decim = 8'd0;
      step();

      // Timeout: 5th accepted sample forces the trigger.
      trig_en = 1'b1; trig_level = 12'd4095; tmo_limit = 16'd5; run = 1'b1;
      step();
      sample_valid = 1'b1; sample_data = 12'd10;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("tmo_we", 32'(ram_wr_en), (k == 4) ? 32'd1 : 32'd0);
      end
      chk("tmo_addr", 32'(ram_wr_addr), 32'd1024);
      chk("tmo_data", 32'(ram_wr_data), 32'd10);
      step();
      chk("tmo_next_addr", 32'(ram_wr_addr), 32'd1025);

      // Reset mid-capture restores every reset value.
      rst = 1'b1;
      step();
      chk_reset_vals("midrst");
      run = 1'b0; sample_valid = 1'b0; trig_en = 1'b0; tmo_limit = 16'd0;
      step();
      rst = 1'b0;
      step();
      chk_reset_vals("post_rst");

      // frame_start coincident with final sample causes no swap.
      run = 1'b1;
      step();
      capture_ramp(0, 1'b1);
      chk("coinc_no_swap", 32'(swap_pulse), 32'd0);
      chk("coinc_disp",    32'(disp_bank),  32'd1);
      step();
      chk("coinc_still_no_swap", 32'(swap_pulse), 32'd0);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk("late_swap_pulse", 32'(swap_pulse), 32'd1);
      chk("late_swap_disp",  32'(disp_bank),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
